// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the alu, the decoder and the arbiter.
package alu_pkg;

  localparam int unsigned ALU_OPW = 6;

  typedef logic [ALU_OPW-1:0] alu_op_t;

  localparam alu_op_t OP_ALU_ADD  = 6'd0;
  localparam alu_op_t OP_ALU_SUB  = 6'd1;
  localparam alu_op_t OP_ALU_AND  = 6'd2;
  localparam alu_op_t OP_ALU_OR   = 6'd3;
  localparam alu_op_t OP_ALU_XOR  = 6'd4;
  localparam alu_op_t OP_ALU_SLL  = 6'd5;
  localparam alu_op_t OP_ALU_SRL  = 6'd6;
  localparam alu_op_t OP_ALU_SRA  = 6'd7;
  localparam alu_op_t OP_ALU_SLT  = 6'd8;
  localparam alu_op_t OP_ALU_SLTU = 6'd9;

  typedef enum logic [0:0] {StEmpty, StFull} rsp_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; undefined opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ALU_ADD:  result = a + b;
      OP_ALU_SUB:  result = a - b;
      OP_ALU_AND:  result = a & b;
      OP_ALU_OR:   result = a | b;
      OP_ALU_XOR:  result = a ^ b;
      OP_ALU_SLL:  result = a << shamt;
      OP_ALU_SRL:  result = a >> shamt;
      OP_ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// one-entry registered response buffer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [OPW-1:0]   i_req0_op,
  input  logic [OPW-1:0]   i_req1_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_result
);

  rsp_state_e       state_q;
  logic             last_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] result_q;

  logic             can_accept;
  logic             grant;
  logic             grant_valid;
  logic             xfer;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;

  // Output buffer may drain and refill in the same cycle.
  assign can_accept = (state_q == StEmpty) || i_rsp_ready;

  always_comb begin
    grant       = 1'b0;
    grant_valid = |i_req_valid;
    case (i_req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    o_req_ready = 2'b00;
    if (can_accept && grant_valid && !i_rst) begin
      o_req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign xfer   = |o_req_ready;
  assign alu_op = alu_op_t'(grant ? i_req1_op : i_req0_op);
  assign alu_a  = grant ? i_req1_a : i_req0_a;
  assign alu_b  = grant ? i_req1_b : i_req0_b;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StEmpty;
      last_q   <= 1'b1;
      rsp_id_q <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (xfer) begin
            state_q  <= StFull;
            last_q   <= grant;
            rsp_id_q <= grant;
            result_q <= alu_result;
          end
        end
        StFull: begin
          if (xfer) begin
            last_q   <= grant;
            rsp_id_q <= grant;
            result_q <= alu_result;
          end else if (i_rsp_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign o_rsp_valid  = (state_q == StFull);
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of the arbiter and response buffer.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [5:0]       i_req0_op, i_req1_op;
  logic [WIDTH-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_result;

  int checks   = 0;
  int failures = 0;

  // Model: last granted requester and the one-entry response buffer.
  int          m_last   = 1;
  bit          m_valid  = 0;
  bit          m_id     = 0;
  logic [31:0] m_result = 0;

  always #5 i_clk = ~i_clk;

  alu_arbiter #(
    .WIDTH (WIDTH),
    .OPW   (6)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req0_op    (i_req0_op),
    .i_req1_op    (i_req1_op),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result)
  );

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = int'(b[4:0]);
    case (op)
      OP_ALU_ADD:  return a + b;
      OP_ALU_SUB:  return a - b;
      OP_ALU_AND:  return a & b;
      OP_ALU_OR:   return a | b;
      OP_ALU_XOR:  return a ^ b;
      OP_ALU_SLL:  return a << s;
      OP_ALU_SRL:  return a >> s;
      OP_ALU_SRA: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
        return r;
      end
      OP_ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ready();
    if (i_rst || (m_valid && !i_rsp_ready)) return 2'b00;
    case (i_req_valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return (m_last == 0) ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [1:0] acc;
    acc = exp_ready();
    @(posedge i_clk);
    if (i_rst) begin
      m_valid = 0; m_id = 0; m_result = 0; m_last = 1;
    end else if (acc[0]) begin
      m_valid = 1; m_id = 0; m_last = 0;
      m_result = ref_alu(i_req0_op, i_req0_a, i_req0_b);
    end else if (acc[1]) begin
      m_valid = 1; m_id = 1; m_last = 1;
      m_result = ref_alu(i_req1_op, i_req1_a, i_req1_b);
    end else if (i_rsp_ready) begin
      m_valid = 0;
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1; i_req_valid = 2'b11; i_rsp_ready = 0;
    i_req0_op = OP_ALU_ADD; i_req1_op = OP_ALU_ADD;
    i_req0_a = 1; i_req0_b = 2; i_req1_a = 3; i_req1_b = 4;
    tick(); tick();
    #1;
    checks++;
    if (o_req_ready !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", o_req_ready);
    end
    checks++;
    if (o_rsp_valid !== 1'b0 || o_rsp_id !== 1'b0 || o_rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_rsp got v=%b id=%b r=%h want 0/0/0", o_rsp_valid, o_rsp_id,
               o_rsp_result);
    end
    tick();
  endtask

  task automatic test_single_add();
    i_rst = 0; i_req_valid = 2'b01; i_rsp_ready = 1;
    i_req0_op = OP_ALU_ADD; i_req0_a = 5; i_req0_b = 7;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++; $display("FAIL add_ready got=%b want=01", o_req_ready);
    end
    tick();
    i_req_valid = 2'b00;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b0 || o_rsp_result !== 32'd12) begin
      failures++;
      $display("FAIL add_rsp got v=%b id=%b r=%0d want 1/0/12", o_rsp_valid, o_rsp_id,
               o_rsp_result);
    end
    tick();
  endtask

  task automatic test_round_robin();
    i_rst = 1; i_req_valid = 2'b00; tick();
    i_rst = 0; i_req_valid = 2'b11; i_rsp_ready = 1;
    i_req0_op = OP_ALU_SUB; i_req0_a = 10;    i_req0_b = 3;
    i_req1_op = OP_ALU_XOR; i_req1_a = 'hF0;  i_req1_b = 'h0F;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (o_req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL rr_ready cycle=%0d got=%b", i, o_req_ready);
      end
      if (i > 0) begin
        checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== ((i - 1) % 2 == 1) ||
            o_rsp_result !== (((i - 1) % 2 == 1) ? 32'hFF : 32'd7)) begin
          failures++;
          $display("FAIL rr_rsp cycle=%0d got v=%b id=%b r=%h", i, o_rsp_valid, o_rsp_id,
                   o_rsp_result);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bit          held_id;
    logic [31:0] held_res;
    held_id = m_id; held_res = m_result;
    i_req_valid = 2'b11; i_rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_req_ready !== 2'b00 || o_rsp_valid !== 1'b1 || o_rsp_id !== held_id ||
          o_rsp_result !== held_res) begin
        failures++;
        $display("FAIL stall cycle=%0d got rdy=%b v=%b id=%b r=%h want 00/1/%b/%h", i,
                 o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, held_id, held_res);
      end
      tick();
    end
    i_rsp_ready = 1;
    #1;
    checks++;
    if (o_req_ready !== (held_id ? 2'b01 : 2'b10)) begin
      failures++; $display("FAIL stall_release got=%b prev_id=%b", o_req_ready, held_id);
    end
    tick();
    #1;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== !held_id) begin
      failures++; $display("FAIL stall_next got v=%b id=%b", o_rsp_valid, o_rsp_id);
    end
  endtask

  task automatic test_shifts();
    i_rsp_ready = 1; i_req_valid = 2'b10;
    i_req1_op = OP_ALU_SRA; i_req1_a = 32'h8000_0000; i_req1_b = 4;
    tick();
    i_req_valid = 2'b01;
    i_req0_op = OP_ALU_SLTU; i_req0_a = 1; i_req0_b = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (o_rsp_id !== 1'b1 || o_rsp_result !== 32'hF800_0000) begin
      failures++; $display("FAIL sra got id=%b r=%h want 1/f8000000", o_rsp_id, o_rsp_result);
    end
    tick();
    #1;
    checks++;
    if (o_rsp_id !== 1'b0 || o_rsp_result !== 32'd1) begin
      failures++; $display("FAIL sltu got id=%b r=%h want 0/1", o_rsp_id, o_rsp_result);
    end
  endtask

  task automatic test_reset_full();
    i_req_valid = 2'b11; i_rsp_ready = 0;
    tick();
    i_rst = 1;
    #1;
    checks++;
    if (o_req_ready !== 2'b00) begin
      failures++; $display("FAIL rstfull_ready got=%b want=00", o_req_ready);
    end
    tick();
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 2'b00) begin
      failures++; $display("FAIL rstfull_rsp got v=%b rdy=%b", o_rsp_valid, o_req_ready);
    end
    i_rst = 0; i_rsp_ready = 1;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++; $display("FAIL rstfull_tie got=%b want=01", o_req_ready);
    end
    tick();
  endtask

  task automatic test_unknown_op();
    i_req_valid = 2'b01; i_rsp_ready = 1;
    i_req0_op = 6'b111111; i_req0_a = $urandom; i_req0_b = $urandom;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++; $display("FAIL unk_ready got=%b want=01", o_req_ready);
    end
    tick();
    i_req_valid = 2'b00;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b0 || o_rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL unk_rsp got v=%b id=%b r=%h want 1/0/0", o_rsp_valid, o_rsp_id,
               o_rsp_result);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      i_rst       = ($urandom_range(0, 49) == 0);
      i_req_valid = 2'($urandom_range(0, 3));
      i_rsp_ready = ($urandom_range(0, 2) != 0);
      i_req0_op   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
      i_req1_op   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
      i_req0_a = $urandom; i_req0_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      i_req1_a = $urandom; i_req1_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      #1;
      checks++;
      if (o_req_ready !== exp_ready()) begin
        failures++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", i, o_req_ready, exp_ready());
      end
      checks++;
      if (o_rsp_valid !== m_valid ||
          (m_valid && (o_rsp_id !== m_id || o_rsp_result !== m_result))) begin
        failures++;
        $display("FAIL rnd_rsp cycle=%0d got v=%b id=%b r=%h want v=%b id=%b r=%h", i,
                 o_rsp_valid, o_rsp_id, o_rsp_result, m_valid, m_id, m_result);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_stall();
    test_shifts();
    test_reset_full();
    test_unknown_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPW, default 6, ALU opcode width.
REQ-003 SHALL have port i_clk, input, 1, the only clock; all state on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_req_valid, input, 2, per-requester request valid (bit k = requester k).
REQ-006 SHALL have port o_req_ready, output, 2, per-requester accept; one-hot or zero.
REQ-007 SHALL have ports i_req0_op / i_req1_op, input, OPW, requested ALU opcode.
REQ-008 SHALL have ports i_req0_a, i_req0_b, i_req1_a, i_req1_b, input, WIDTH, operands.
REQ-009 SHALL have port o_rsp_valid, output, 1, result register holds a valid response.
REQ-010 SHALL have port i_rsp_ready, input, 1, consumer accepts the response.
REQ-011 SHALL have port o_rsp_id, output, 1, index of requester owning the response.
REQ-012 SHALL have port o_rsp_result, output, WIDTH, registered ALU result.

Function
REQ-013 SHALL share one combinational ALU between two requesters; a request transfers when i_req_valid[k] && o_req_ready[k].
REQ-014 SHALL compute can_accept = !o_rsp_valid || i_rsp_ready (one-entry output buffer, drain and refill same cycle allowed).
REQ-015 SHALL assert o_req_ready[k] only when can_accept and requester k holds the grant; o_req_ready SHALL NOT depend on the requester's own ready-path (valid-to-ready combinational allowed, no loop through i_rsp_ready beyond REQ-014).
REQ-016 SHALL grant: only one valid -> that one; both valid -> requester not granted last (round-robin); none -> no grant.
REQ-017 SHALL update the last-grant pointer only on an accepted transfer; a stalled cycle (can_accept=0) SHALL NOT move it.
REQ-018 SHALL drive the granted requester's op/a/b into the ALU and register result and id on transfer: latency exactly 1 cycle (accept at N -> o_rsp_valid at N+1).
REQ-019 SHALL hold o_rsp_valid, o_rsp_id, o_rsp_result stable while o_rsp_valid && !i_rsp_ready.
REQ-020 SHALL clear o_rsp_valid when response consumed with no new transfer in the same cycle.
REQ-021 SHALL pass unknown opcodes through; ALU returns 0, arbiter treats as normal transfer.
REQ-022 SHALL express state as two-state FSM: EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1); EMPTY->FULL on transfer; FULL->EMPTY on consume without transfer; FULL->FULL on consume+transfer or stall.
REQ-023 SHALL keep shift amount from b[4:0] and all arithmetic modulo 2^WIDTH, as defined by the ALU.

Reset
REQ-024 SHALL, on i_rst high at a clock edge, set o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, last-grant=1 (requester 0 wins first tie).
REQ-025 SHALL drive o_req_ready=0 while i_rst is high; in-flight response SHALL be discarded.
REQ-026 SHALL have no asynchronous reset logic.

Structure
REQ-027 SHALL take opcode constants (OP_ALU_*) and an alu_op_t typedef of OPW bits from shared package alu_pkg, also used by the alu module and decoder.
REQ-028 SHALL instantiate exactly one existing alu sub-module; arbitration, FSM and output register live in alu_arbiter.
REQ-029 SHALL contain no multi-cycle ALU operations; new ops are added in alu_pkg/alu only.

Verification
REQ-030 Req0 only ADD a=5,b=7, rsp_ready=1 -> ready[0] same cycle; next cycle rsp_valid=1, id=0, result=12.
REQ-031 Both valid continuously, req0 SUB 10-3, req1 XOR 0xF0^0x0F, rsp_ready=1 -> grants 0,1,0,1...; results 7 (id0), 0xFF (id1) alternating.
REQ-032 Response FULL, rsp_ready=0 for 3 cycles, both valid -> o_req_ready=00, outputs and pointer frozen; on rsp_ready=1 the pending-priority requester accepted same cycle.
REQ-033 SRA a=0x80000000,b=4 from req1 -> result 0xF8000000, id=1; SLTU a=1,b=0xFFFFFFFF -> 1.
REQ-034 i_rst asserted while FULL with both valid -> next cycle rsp_valid=0, o_req_ready=00 during reset; first tie after release grants requester 0.
REQ-035 Undefined opcode 6'b111111 from req0 -> transfer accepted, result 0, id 0.
